// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared constants and state type for the 8-way round-robin
//                arbiter and its priority picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

   // Number of requesters and the width of an index into them
   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   // Arbiter state: waiting for a request, or a grant is held
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick8
//  Description : Combinational round-robin picker. Rotates the request vector
//                so the priority pointer lands on bit 0, finds the first set
//                bit with fixed priority, then un-rotates the offset back into
//                an absolute requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [N_REQ-1:0] w_rot;
   logic [IDX_W-1:0] w_off;

   // Rotate so that requester i_ptr sits at bit 0; the index sum wraps mod 8
   always_comb begin
      w_rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_rot[i] = i_req[i_ptr + IDX_W'(i)];
      end
   end

   // Fixed-priority find-first: scan from the top so the lowest set bit wins
   always_comb begin
      w_off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = IDX_W'(i);
         end
      end
   end

   // Un-rotate the winning offset back to an absolute index
   always_comb begin
      o_idx = w_off + i_ptr;
      o_any = |i_req;
   end

endmodule : rr_pick8
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : Eight-way round-robin arbiter with a hold-time limit.
//                Arbitration happens only in IDLE; a grant is held until the
//                holder drops its request or reaches HOLD_MAX cycles, after
//                which the pointer moves past the holder and one idle cycle
//                follows. Grant outputs decode from registered state only.
//                HOLD_MAX legal range is 2..256.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] i_req,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_gnt_valid,
   output logic             o_timeout
);

   // Counter is just wide enough to reach HOLD_MAX-1, where the forced
   // release fires, so it can never wrap.
   localparam int                HCNT_W      = $clog2(HOLD_MAX);
   localparam logic [HCNT_W-1:0] c_HCNT_LAST = HCNT_W'(HOLD_MAX - 1);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  w_ptr_nxt;
   logic [HCNT_W-1:0] r_hcnt;
   logic [HCNT_W-1:0] w_hcnt_nxt;
   logic              r_timeout;
   logic              w_timeout_nxt;

   logic [IDX_W-1:0]  w_pick_idx;
   logic              w_pick_any;
   logic              w_holder_req;

   rr_pick8 u_pick (
      .i_req (i_req),
      .i_ptr (r_ptr),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   assign w_holder_req = i_req[r_idx];

   // State register; reset overrides any release or timeout on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_ptr     <= '0;
         r_hcnt    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hcnt    <= w_hcnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // Next-state logic: arbitrate in IDLE, count or release in GRANT.
   // The pointer moves only on release, so the released holder ranks last.
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_ptr_nxt     = r_ptr;
      w_hcnt_nxt    = r_hcnt;
      w_timeout_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_state_nxt = GRANT;
               w_idx_nxt   = w_pick_idx;
               w_hcnt_nxt  = '0;
            end
         end
         GRANT: begin
            if (!w_holder_req) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = r_idx + IDX_W'(1);
               w_hcnt_nxt  = '0;
            end else if (r_hcnt == c_HCNT_LAST) begin
               w_state_nxt   = IDLE;
               w_ptr_nxt     = r_idx + IDX_W'(1);
               w_hcnt_nxt    = '0;
               w_timeout_nxt = 1'b1;
            end else begin
               w_hcnt_nxt = r_hcnt + HCNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // One-hot grant decoded from the registered index, gated by the state
   generate
      for (genvar g = 0; g < N_REQ; g++) begin : g_gnt_dec
         assign o_gnt[g] = (r_state == GRANT) && (r_idx == IDX_W'(g));
      end
   endgenerate

   assign o_gnt_idx   = r_idx;
   assign o_gnt_valid = (r_state == GRANT);
   assign o_timeout   = r_timeout;

endmodule : rr_arbiter8
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Scoreboard bench for rr_arbiter8. Two instances (HOLD_MAX 16
//                and 2) share the same request stimulus; a behavioural model
//                of each predicts the post-edge outputs, which a separate
//                monitor pops and compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

   typedef struct {
      int holder;   // current grant holder, -1 when idle
      int ptr;      // first requester searched at the next arbitration
      int held;     // cycles the holder has had the grant so far
      bit to;       // forced-release pulse visible this cycle
   } mdl_t;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       v;
      logic       to;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;

   logic [7:0] gA, gB;
   logic [2:0] iA, iB;
   logic       vA, vB, tA, tB;

   exp_t qA[$];
   exp_t qB[$];
   exp_t eA, eB;
   int   logA[$];
   logic prevA = 1'b0;
   int   toB_cnt = 0;
   int   checks = 0;
   int   failures = 0;
   mdl_t mA, mB;

   always #5 clk = ~clk;

   rr_arbiter8 #(.HOLD_MAX(16)) u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .i_req       (req),
      .o_gnt       (gA),
      .o_gnt_idx   (iA),
      .o_gnt_valid (vA),
      .o_timeout   (tA)
   );

   rr_arbiter8 #(.HOLD_MAX(2)) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .i_req       (req),
      .o_gnt       (gB),
      .o_gnt_idx   (iB),
      .o_gnt_valid (vB),
      .o_timeout   (tB)
   );

   // Reference model: one clock edge of the arbitration rules
   function automatic mdl_t step(input mdl_t m, input logic [7:0] r,
                                 input bit rs, input int hold);
      mdl_t n;
      n    = m;
      n.to = 1'b0;
      if (rs) begin
         n.holder = -1;
         n.ptr    = 0;
         n.held   = 0;
      end else if (m.holder < 0) begin
         for (int k = 0; k < 8; k++) begin
            int j;
            j = (m.ptr + k) % 8;
            if (r[j] && n.holder < 0) begin
               n.holder = j;
               n.held   = 1;
            end
         end
      end else if (!r[m.holder]) begin
         n.ptr    = (m.holder + 1) % 8;
         n.holder = -1;
      end else if (m.held == hold) begin
         n.ptr    = (m.holder + 1) % 8;
         n.holder = -1;
         n.to     = 1'b1;
      end else begin
         n.held = m.held + 1;
      end
      return n;
   endfunction

   function automatic exp_t expect_of(input mdl_t m);
      exp_t e;
      e.v   = (m.holder >= 0);
      e.gnt = e.v ? (8'h01 << m.holder) : 8'h00;
      e.idx = e.v ? 3'(m.holder) : 3'd0;
      e.to  = m.to;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_grant(input string nm, input int pos, input int exp);
      int got;
      got = (pos < logA.size()) ? logA[pos] : -1;
      chk(nm, got, exp);
   endtask

   // Drive one cycle of stimulus and queue what both DUTs must show after it
   task automatic cyc(input logic [7:0] r, input bit rs);
      @(negedge clk);
      req = r;
      rst = rs;
      mA  = step(mA, r, rs, 16);
      mB  = step(mB, r, rs, 2);
      qA.push_back(expect_of(mA));
      qB.push_back(expect_of(mB));
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare each DUT against the oldest queued expectation
   always @(posedge clk) begin
      #1;
      if (qA.size() > 0) begin
         eA = qA.pop_front();
         chk("A.gnt", gA, eA.gnt);
         chk("A.valid", vA, eA.v);
         chk("A.timeout", tA, eA.to);
         if (eA.v) chk("A.idx", iA, eA.idx);
      end
      if (qB.size() > 0) begin
         eB = qB.pop_front();
         chk("B.gnt", gB, eB.gnt);
         chk("B.valid", vB, eB.v);
         chk("B.timeout", tB, eB.to);
         if (eB.v) chk("B.idx", iB, eB.idx);
      end
      if (vA === 1'b1 && prevA !== 1'b1) logA.push_back(int'(iA));
      prevA = vA;
      if (tB === 1'b1) toB_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      int         t0;
      mA = '{holder: -1, ptr: 0, held: 0, to: 1'b0};
      mB = '{holder: -1, ptr: 0, held: 0, to: 1'b0};

      // Reset then idle with no requests
      cyc(8'h00, 1'b1);
      repeat (5) cyc(8'h00, 1'b0);

      // Two requesters held: 0 times out, then 7, then 0 again
      cyc(8'h00, 1'b1);
      settle();
      logA.delete();
      repeat (40) cyc(8'h81, 1'b0);
      settle();
      chk_grant("seq81[0]", 0, 0);
      chk_grant("seq81[1]", 1, 7);
      chk_grant("seq81[2]", 2, 0);

      // All requesting; each holder drops for one cycle after two grant cycles
      cyc(8'h00, 1'b1);
      settle();
      logA.delete();
      for (int c = 0; c < 80 && logA.size() < 9; c++) begin
         r = 8'hFF;
         if (mA.holder >= 0 && mA.held == 2) r[mA.holder] = 1'b0;
         cyc(r, 1'b0);
      end
      settle();
      for (int i = 0; i < 9; i++) chk_grant($sformatf("seqFF[%0d]", i), i, i % 8);

      // Single-cycle pulse on requester 2, then pointer must sit at 3
      cyc(8'h00, 1'b1);
      settle();
      logA.delete();
      cyc(8'h04, 1'b0);
      cyc(8'h00, 1'b0);
      cyc(8'h00, 1'b0);
      cyc(8'h0A, 1'b0);
      cyc(8'h0A, 1'b0);
      cyc(8'h00, 1'b0);
      cyc(8'h00, 1'b0);
      settle();
      chk_grant("pulse[0]", 0, 2);
      chk_grant("pulse[1]", 1, 3);

      // Reset while requester 5 holds at hcnt=7; pointer must return to 0
      cyc(8'h00, 1'b1);
      settle();
      logA.delete();
      for (int c = 0; c < 40 && !(mA.holder == 5 && mA.held == 8); c++) cyc(8'h20, 1'b0);
      cyc(8'h20, 1'b1);
      cyc(8'h21, 1'b0);
      cyc(8'h21, 1'b0);
      cyc(8'h00, 1'b0);
      cyc(8'h00, 1'b0);
      settle();
      chk_grant("rstmid[0]", 0, 5);
      chk_grant("rstmid[1]", 1, 0);

      // HOLD_MAX=2 instance: 2 on, 1 off, timeout every third cycle
      cyc(8'h00, 1'b1);
      settle();
      t0 = toB_cnt;
      repeat (12) cyc(8'h01, 1'b0);
      settle();
      chk("B.timeout_count", toB_cnt - t0, 4);

      // Randomized traffic with occasional resets
      r = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0:       r = 8'h01 << $urandom_range(0, 7);
               1:       r = 8'($urandom) & 8'($urandom);
               2:       r = 8'h00;
               default: r = 8'($urandom);
            endcase
         end
         cyc(r, $urandom_range(0, 99) == 0);
      end
      settle();
      chk("drain", qA.size() + qB.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rr_arbiter8
`default_nettype wire
